// File: rtl/traffic_pkg.sv
// Shared types and constants for the N-phase traffic sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  // Width of the phase index; a single approach still needs one bit.
  function automatic int phase_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_PHASES  = 4;
  localparam int DEF_TIMER_WIDTH = 4;
  localparam int DEF_GREEN_TIME  = 12;
  localparam int DEF_YELLOW_TIME = 3;
  localparam int DEF_ALLRED_TIME = 1;
  localparam int DEF_MIN_GREEN   = 4;

  // Seven-segment patterns, active-low, bit order gfedcba. Index = digit.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern (gfedcba); codes >9 blank.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd (in, 4) digit value; seg (out, 7) active-low segments.
module seg7_decoder
  import traffic_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_DIGITS[bcd];
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase traffic-light sequencer: green/yellow/all-red rotation with gap-out and flash mode.
// Latency: state and lamps update on the clk edge of a tick strobe; all outputs registered.
// Backpressure: none; tick=0 freezes all sequencing state.
// Ports: clk, rstn (async active-low), tick, demand[N], flash_req in;
//        green/yellow/red[N], phase_idx, remaining, flashing out.
// Optional: SEG_DISPLAY_EN adds seg[6:0] (active-low gfedcba) and an[1:0]
//           (active-low digit enables) showing remaining+1 in decimal.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = DEF_NUM_PHASES,
  parameter int TIMER_WIDTH = DEF_TIMER_WIDTH,
  parameter int GREEN_TIME  = DEF_GREEN_TIME,
  parameter int YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int ALLRED_TIME = DEF_ALLRED_TIME,
  parameter int MIN_GREEN   = DEF_MIN_GREEN
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            tick,
  input  logic [NUM_PHASES-1:0]           demand,
  input  logic                            flash_req,
  output logic [NUM_PHASES-1:0]           green,
  output logic [NUM_PHASES-1:0]           yellow,
  output logic [NUM_PHASES-1:0]           red,
  output logic [phase_w(NUM_PHASES)-1:0]  phase_idx,
  output logic [TIMER_WIDTH-1:0]          remaining,
  output logic                            flashing
`ifdef SEG_DISPLAY_EN
  ,
  output logic [6:0]                      seg,
  output logic [1:0]                      an
`endif
);

  localparam int PW = phase_w(NUM_PHASES);
  localparam int TW = TIMER_WIDTH;

  localparam logic [TW-1:0] G_LOAD  = TW'(GREEN_TIME - 1);
  localparam logic [TW-1:0] Y_LOAD  = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] A_LOAD  = TW'(ALLRED_TIME - 1);
  // Once remaining drops to this value MIN_GREEN ticks of green have been served.
  localparam logic [TW-1:0] GAP_MAX = TW'(GREEN_TIME - MIN_GREEN);
  localparam logic [PW-1:0] LAST_PH = PW'(NUM_PHASES - 1);

  state_t                state_q, state_n;
  logic [PW-1:0]         phase_n;
  logic [TW-1:0]         rem_n;
  logic                  first_q, first_n;  // still in the very first all-red after reset
  logic                  fy_q, fy_n;        // flash-mode yellow level
  logic [NUM_PHASES-1:0] cur_oh, nxt_oh, others;
  logic                  gap_out;
  logic [NUM_PHASES-1:0] green_n, yellow_n, red_n;

  always_comb begin
    cur_oh  = NUM_PHASES'(1) << phase_idx;
    others  = demand & ~cur_oh;
    gap_out = (remaining <= GAP_MAX) && !demand[phase_idx] && (|others);

    state_n = state_q;
    phase_n = phase_idx;
    rem_n   = remaining;
    first_n = first_q;
    fy_n    = fy_q;

    if (tick) begin
      case (state_q)
        ST_ALLRED: begin
          if (remaining != '0) begin
            rem_n = remaining - TW'(1);
          end else begin
            first_n = 1'b0;
            if (flash_req) begin
              state_n = ST_FLASH;
              rem_n   = '0;
              fy_n    = 1'b1;
            end else begin
              state_n = ST_GREEN;
              rem_n   = G_LOAD;
              if (!first_q)
                phase_n = (phase_idx == LAST_PH) ? '0 : phase_idx + PW'(1);
            end
          end
        end
        ST_GREEN: begin
          // Expiry and gap-out on the same tick collapse into one move to yellow.
          if (remaining == '0 || gap_out) begin
            state_n = ST_YELLOW;
            rem_n   = Y_LOAD;
          end else begin
            rem_n = remaining - TW'(1);
          end
        end
        ST_YELLOW: begin
          if (remaining == '0) begin
            state_n = ST_ALLRED;
            rem_n   = A_LOAD;
          end else begin
            rem_n = remaining - TW'(1);
          end
        end
        ST_FLASH: begin
          // phase_idx is untouched, so resuming rotates on to the next approach.
          if (!flash_req) begin
            state_n = ST_ALLRED;
            rem_n   = A_LOAD;
          end else begin
            fy_n = ~fy_q;
          end
        end
        default: state_n = ST_ALLRED;
      endcase
    end

    // Lamps are registered from the next state so they line up with it.
    nxt_oh   = NUM_PHASES'(1) << phase_n;
    green_n  = '0;
    yellow_n = '0;
    red_n    = '1;
    case (state_n)
      ST_GREEN:  begin green_n  = nxt_oh; red_n = ~nxt_oh; end
      ST_YELLOW: begin yellow_n = nxt_oh; red_n = ~nxt_oh; end
      ST_FLASH:  begin yellow_n = {NUM_PHASES{fy_n}}; red_n = '0; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_ALLRED;
      phase_idx <= '0;
      remaining <= A_LOAD;
      first_q   <= 1'b1;
      fy_q      <= 1'b0;
      green     <= '0;
      yellow    <= '0;
      red       <= '1;
      flashing  <= 1'b0;
    end else begin
      state_q   <= state_n;
      phase_idx <= phase_n;
      remaining <= rem_n;
      first_q   <= first_n;
      fy_q      <= fy_n;
      green     <= green_n;
      yellow    <= yellow_n;
      red       <= red_n;
      flashing  <= (state_n == ST_FLASH);
    end
  end

`ifdef SEG_DISPLAY_EN
  logic       an_sel_q;  // 1: tens digit currently driven
  logic [7:0] disp_val;
  logic [3:0] digit;
  logic [6:0] seg_dec;

  // Digit is chosen for the selection that will be live after the edge,
  // so seg and an always change together.
  always_comb begin
    disp_val = 8'(remaining) + 8'd1;
    digit    = an_sel_q ? 4'(disp_val % 8'd10) : 4'(disp_val / 8'd10);
  end

  seg7_decoder u_seg7_decoder (
    .bcd (digit),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an_sel_q <= 1'b0;
      an       <= 2'b11;
      seg      <= SEG_BLANK;
    end else begin
      an_sel_q <= ~an_sel_q;
      an       <= an_sel_q ? 2'b10 : 2'b01;
      seg      <= (state_n == ST_FLASH) ? SEG_BLANK : seg_dec;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl (default parameters, 4 phases).
// Latency: n/a.
// Backpressure: n/a.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tick;
  logic [3:0] demand;
  logic       flash_req;
  logic [3:0] green, yellow, red;
  logic [1:0] phase_idx;
  logic [3:0] remaining;
  logic       flashing;
`ifdef SEG_DISPLAY_EN
  logic [6:0] seg;
  logic [1:0] an;
`endif

  traffic_phase_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .tick      (tick),
    .demand    (demand),
    .flash_req (flash_req),
    .green     (green),
    .yellow    (yellow),
    .red       (red),
    .phase_idx (phase_idx),
    .remaining (remaining),
    .flashing  (flashing)
`ifdef SEG_DISPLAY_EN
    ,
    .seg       (seg),
    .an        (an)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // ---------------- reference model ----------------
  // Interval kind: 0 all-red, 1 green, 2 yellow, 3 flash. Time counts up.
  int m_kind, m_phase, m_el, m_first, m_fy;

  function automatic int dur(input int k);
    case (k)
      1: return 12;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_kind = 0; m_phase = 0; m_el = 0; m_first = 1; m_fy = 0;
  endtask

  task automatic model_step(input logic tk, input logic [3:0] dm, input logic fr);
    bit others, gap;
    if (!tk) return;
    case (m_kind)
      0: if (m_el < dur(0) - 1) m_el++;
         else begin
           if (fr) begin m_kind = 3; m_fy = 1; end
           else begin
             m_kind = 1;
             if (m_first == 0) m_phase = (m_phase + 1) % 4;
           end
           m_first = 0; m_el = 0;
         end
      1: begin
           others = 0;
           for (int i = 0; i < 4; i++) if (i != m_phase && dm[i]) others = 1;
           gap = (m_el >= 4 - 1) && !dm[m_phase] && others;
           if (m_el == dur(1) - 1 || gap) begin m_kind = 2; m_el = 0; end
           else m_el++;
         end
      2: if (m_el == dur(2) - 1) begin m_kind = 0; m_el = 0; end else m_el++;
      default: if (!fr) begin m_kind = 0; m_el = 0; end else m_fy = 1 - m_fy;
    endcase
  endtask

  task automatic model_expect(output logic [3:0] g, output logic [3:0] y, output logic [3:0] r,
                              output logic [1:0] ph, output logic [3:0] rm, output logic fl);
    for (int i = 0; i < 4; i++) begin
      g[i] = (m_kind == 1 && i == m_phase);
      y[i] = (m_kind == 2 && i == m_phase) || (m_kind == 3 && m_fy == 1);
      r[i] = (m_kind != 3) && !((m_kind == 1 || m_kind == 2) && i == m_phase);
    end
    ph = 2'(m_phase);
    rm = (m_kind == 3) ? 4'd0 : 4'(dur(m_kind) - 1 - m_el);
    fl = (m_kind == 3);
  endtask

  // ---------------- helpers ----------------
  task automatic cmp(input string name, input logic [3:0] g, input logic [3:0] y,
                     input logic [3:0] r, input logic [1:0] ph, input logic [3:0] rm,
                     input logic fl);
    checks++;
    if ({green, yellow, red, phase_idx, remaining, flashing} === {g, y, r, ph, rm, fl})
      passes++;
    else
      $display("FAIL %s: got g=%b y=%b r=%b ph=%0d rem=%0d fl=%b want g=%b y=%b r=%b ph=%0d rem=%0d fl=%b",
               name, green, yellow, red, phase_idx, remaining, flashing, g, y, r, ph, rm, fl);
  endtask

  task automatic cmp_int(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  task automatic cyc(input logic tk, input logic [3:0] dm, input logic fr);
    tick = tk; demand = dm; flash_req = fr;
    model_step(tk, dm, fr);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; tick = 1'b0; demand = 4'h0; flash_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset", 4'b0000, 4'b0000, 4'b1111, 2'd0, 4'd0, 1'b0);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic       tk;
    logic [3:0] dm;
    logic       fr;
    int         n;
    logic [3:0] g, y, r;
    logic [1:0] ph;
    logic [3:0] rm;
    logic       fl;
  } vec_t;

  vec_t vecs[21];

  logic [3:0] eg, ey, er, erm;
  logic [1:0] eph;
  logic       efl;

  initial begin
    int cnt_g, cnt_y, freeze_bad, bound;
    logic [3:0] dm, prev_rem;
    logic fr, tk;

    //         tk  dm    fr  n   green    yellow   red      ph  rem  fl
    vecs[0]  = '{1, 4'hf, 0, 1,  4'b0001, 4'b0000, 4'b1110, 0, 11, 0};
    vecs[1]  = '{1, 4'hf, 0, 11, 4'b0001, 4'b0000, 4'b1110, 0, 0,  0};
    vecs[2]  = '{1, 4'hf, 0, 1,  4'b0000, 4'b0001, 4'b1110, 0, 2,  0};
    vecs[3]  = '{1, 4'hf, 0, 2,  4'b0000, 4'b0001, 4'b1110, 0, 0,  0};
    vecs[4]  = '{1, 4'hf, 0, 1,  4'b0000, 4'b0000, 4'b1111, 0, 0,  0};
    vecs[5]  = '{1, 4'hf, 0, 1,  4'b0010, 4'b0000, 4'b1101, 1, 11, 0};
    vecs[6]  = '{0, 4'h0, 1, 5,  4'b0010, 4'b0000, 4'b1101, 1, 11, 0};
    vecs[7]  = '{1, 4'h1, 0, 3,  4'b0010, 4'b0000, 4'b1101, 1, 8,  0};
    vecs[8]  = '{1, 4'h1, 0, 1,  4'b0000, 4'b0010, 4'b1101, 1, 2,  0};
    vecs[9]  = '{1, 4'h0, 0, 3,  4'b0000, 4'b0000, 4'b1111, 1, 0,  0};
    vecs[10] = '{1, 4'h0, 0, 1,  4'b0100, 4'b0000, 4'b1011, 2, 11, 0};
    vecs[11] = '{1, 4'h0, 0, 11, 4'b0100, 4'b0000, 4'b1011, 2, 0,  0};
    vecs[12] = '{1, 4'h0, 0, 1,  4'b0000, 4'b0100, 4'b1011, 2, 2,  0};
    vecs[13] = '{1, 4'hf, 1, 3,  4'b0000, 4'b0000, 4'b1111, 2, 0,  0};
    vecs[14] = '{1, 4'hf, 1, 1,  4'b0000, 4'b1111, 4'b0000, 2, 0,  1};
    vecs[15] = '{1, 4'hf, 1, 1,  4'b0000, 4'b0000, 4'b0000, 2, 0,  1};
    vecs[16] = '{0, 4'hf, 0, 3,  4'b0000, 4'b0000, 4'b0000, 2, 0,  1};
    vecs[17] = '{1, 4'hf, 1, 1,  4'b0000, 4'b1111, 4'b0000, 2, 0,  1};
    vecs[18] = '{1, 4'hf, 0, 1,  4'b0000, 4'b0000, 4'b1111, 2, 0,  0};
    vecs[19] = '{1, 4'hf, 0, 1,  4'b1000, 4'b0000, 4'b0111, 3, 11, 0};
    vecs[20] = '{1, 4'hf, 0, 16, 4'b0001, 4'b0000, 4'b1110, 0, 11, 0};

    // ---- table-driven sequence from reset ----
    do_reset();
    for (int v = 0; v < 21; v++) begin
      for (int k = 0; k < vecs[v].n; k++) cyc(vecs[v].tk, vecs[v].dm, vecs[v].fr);
      cmp($sformatf("vec%0d", v), vecs[v].g, vecs[v].y, vecs[v].r, vecs[v].ph, vecs[v].rm, vecs[v].fl);
`ifdef SEG_DISPLAY_EN
      if (vecs[v].fl) cmp_int($sformatf("seg_blank%0d", v), int'(seg), 127);
`endif
    end

    // ---- tick strobed every 5 cycles: durations scale x5, frozen between ----
    do_reset();
    cnt_g = 0; cnt_y = 0; freeze_bad = 0; prev_rem = remaining;
    for (int i = 0; i < 200; i++) begin
      tk = ((i % 5) == 4);
      cyc(tk, 4'hf, 1'b0);
      if (!tk && remaining != prev_rem) freeze_bad++;
      prev_rem = remaining;
      if (green[0]) cnt_g++;
      if (yellow[0]) cnt_y++;
      if (cnt_y > 0 && red == 4'b1111) break;
    end
    cmp_int("slow_green_cycles", cnt_g, 60);
    cmp_int("slow_yellow_cycles", cnt_y, 15);
    cmp_int("slow_freeze", freeze_bad, 0);

    // ---- flash requested mid-green ----
    do_reset();
    repeat (5) cyc(1'b1, 4'hf, 1'b0);
    cnt_g = 0; cnt_y = 0; bound = 0;
    while (!flashing && bound < 40) begin
      cyc(1'b1, 4'hf, 1'b1);
      if (green[0]) cnt_g++;
      if (yellow[0] && !flashing) cnt_y++;
      bound++;
    end
    cmp_int("flash_green_rest", cnt_g, 7);
    cmp_int("flash_yellow", cnt_y, 3);
    cmp("flash_enter", 4'b0000, 4'b1111, 4'b0000, 2'd0, 4'd0, 1'b1);
    cyc(1'b1, 4'hf, 1'b1);
    cmp("flash_toggle", 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'd0, 1'b1);
    cyc(1'b1, 4'hf, 1'b0);
    cmp("flash_exit", 4'b0000, 4'b0000, 4'b1111, 2'd0, 4'd0, 1'b0);
    cyc(1'b1, 4'hf, 1'b0);
    cmp("flash_resume", 4'b0010, 4'b0000, 4'b1101, 2'd1, 4'd11, 1'b0);

    // ---- asynchronous reset mid-yellow ----
    do_reset();
    repeat (13) cyc(1'b1, 4'hf, 1'b0);
    cmp("pre_rst_yellow", 4'b0000, 4'b0001, 4'b1110, 2'd0, 4'd2, 1'b0);
    #3 rstn = 1'b0;
    #1 cmp("async_rst", 4'b0000, 4'b0000, 4'b1111, 2'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    cyc(1'b1, 4'hf, 1'b0);
    cmp("rst_restart", 4'b0001, 4'b0000, 4'b1110, 2'd0, 4'd11, 1'b0);

`ifdef SEG_DISPLAY_EN
    // ---- display reads 12 during green with remaining=11 ----
    begin
      logic [1:0] prev_an;
      cyc(1'b0, 4'hf, 1'b0);
      prev_an = an;
      for (int i = 0; i < 2; i++) begin
        cyc(1'b0, 4'hf, 1'b0);
        cmp_int("an_toggle", int'(an), int'(~prev_an));
        if (an == 2'b10) cmp_int("seg_units", int'(seg), int'(7'b0100100));
        else             cmp_int("seg_tens", int'(seg), int'(7'b1111001));
        prev_an = an;
      end
    end
`endif

    // ---- randomized run against the reference model ----
    do_reset();
    dm = 4'hf; fr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) dm = 4'($urandom);
      if ($urandom_range(0, 150) == 0) fr = ~fr;
      tk = ($urandom_range(0, 2) != 0);
      cyc(tk, dm, fr);
      model_expect(eg, ey, er, eph, erm, efl);
      cmp($sformatf("rand%0d", i), eg, ey, er, eph, erm, efl);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised N-phase traffic-light sequencer, successor to the fixed two-way NS/EW controller. It rotates right-of-way through NUM_PHASES approaches with green, yellow and all-red clearance intervals, all counted in external ticks. It adds demand-driven green gap-out and a flashing-yellow night mode. It sits under the board top, driving lamp outputs directly and optionally a 2-digit seven-segment countdown.

Parameters:
NUM_PHASES, 4, number of approaches (≥2)
TIMER_WIDTH, 4, countdown register width
GREEN_TIME, 12, green duration in ticks (1..2^TIMER_WIDTH)
YELLOW_TIME, 3, yellow duration in ticks (1..2^TIMER_WIDTH)
ALLRED_TIME, 1, all-red clearance in ticks (1..2^TIMER_WIDTH)
MIN_GREEN, 4, minimum green served before gap-out (1..GREEN_TIME)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
tick  in  1  one-cycle timebase strobe; timer advances only when high
demand  in  NUM_PHASES  per-phase vehicle presence, level, synchronous to clk
flash_req  in  1  night-mode request, level
green  out  NUM_PHASES  per-phase green lamp
yellow  out  NUM_PHASES  per-phase yellow lamp
red  out  NUM_PHASES  per-phase red lamp
phase_idx  out  max(1,$clog2(NUM_PHASES))  phase currently or last holding right-of-way
remaining  out  TIMER_WIDTH  ticks left in current interval minus one
flashing  out  1  high while in FLASH

Behaviour:
- Single clock clk; reset asynchronous, active-low (rstn). All outputs registered.
- Reset values: state ALLRED, red all ones, green/yellow all zeros, phase_idx 0, remaining ALLRED_TIME-1, flashing 0.
- States: ALLRED, GREEN, YELLOW, FLASH.
- Timer: on state entry load DUR-1. On tick with remaining≠0, decrement. On tick with remaining==0, transition. Each interval therefore lasts exactly DUR ticks.
- ALLRED: all red. On expiry:
  - flash_req=1 → FLASH.
  - Otherwise → GREEN; phase_idx advances to (phase_idx+1) mod NUM_PHASES, wrapping NUM_PHASES-1→0.
  - Exception: the first ALLRED after reset enters GREEN with phase_idx 0 (no advance).
- GREEN: green[phase_idx]=1; red asserted on all other phases. On expiry → YELLOW.
- Gap-out: on a tick in GREEN, go to YELLOW early when all of the following hold:
  - remaining ≤ GREEN_TIME-MIN_GREEN;
  - demand[phase_idx]=0;
  - at least one other demand bit is 1.
  Gap-out has the same effect as expiry.
- YELLOW: yellow[phase_idx]=1; others red. On expiry → ALLRED.
- flash_req is honoured only at an ALLRED expiry. It never truncates a green or yellow interval.
- FLASH:
  - red=0, green=0, flashing=1; yellow is all ones or all zeros, toggling on every tick (starts all ones).
  - remaining is held at 0.
  - On a tick with flash_req=0 → ALLRED with full duration. phase_idx is not advanced on FLASH entry, so resume begins at phase_idx+1.
- Simultaneous events: expiry and gap-out on the same tick → single transition to YELLOW. tick=0 freezes all state regardless of demand or flash_req.
- Invariant: at most one phase is non-red outside FLASH. Never green and yellow together on any phase.
- Reset mid-operation returns to the reset values immediately (asynchronous assert). Release is synchronous to clk.

Optional Feature:
SEG_DISPLAY_EN:
- Defined:
  - Adds ports seg (out, 7, active-low, bit order gfedcba) and an (out, 2, active-low digit enables).
  - Displays remaining+1 in decimal, multiplexed: an toggles every clk cycle, an[0]=units, an[1]=tens.
  - Blank (seg all ones) in FLASH.
  - Requires every duration ≤99.
  - seg/an reset to all ones.
- Undefined: ports and logic are absent; the rest of the block is unchanged.

Decomposition:
- Package traffic_pkg: state enum (ALLRED, GREEN, YELLOW, FLASH); phase-index width function; default duration constants; seven-segment digit lookup constants.
- Sub-module seg7_decoder: 4-bit BCD in → 7-bit active-low segments out; instantiated only under SEG_DISPLAY_EN.

Test Plan:
- tick=1 continuously, demand=all ones, flash_req=0, rstn released at cycle 0:
  - ALLRED 1 cycle;
  - green[0] cycles 1-12, then yellow[0] 3 cycles, ALLRED 1 cycle;
  - green[1] starts at cycle 17;
  - phase_idx wraps 3→0 after 64 cycles.
- Gap-out: in phase 0, demand=4'b0010 from green entry:
  - green[0] lasts exactly MIN_GREEN=4 ticks, then yellow[0];
  - with demand=4'b0000 instead, green lasts the full 12.
- tick strobed once every 5 cycles: every interval duration scales ×5; state is frozen between strobes.
- flash_req raised mid-green: green and yellow complete; FLASH is entered at the ALLRED expiry with yellow toggling each tick; drop flash_req → 1-tick ALLRED, then green[phase_idx+1].
- Assert rstn=0 mid-yellow, asynchronously between edges: outputs reach reset values before the next clk edge; after release, the sequence restarts at phase 0.
- SEG_DISPLAY_EN defined: during green with remaining=11, the display reads 12 (tens=1 on an[1], units=2 on an[0]); digits alternate each cycle; the display is blank in FLASH.
